// File: rtl/proj_unidade_controle.sv
// Chess-drill control unit: Moore FSM that sequences proj_fluxo_dados.
// Define PENALIDADE_ERRO_EN to pulse decresceT on a wrong move (timer penalty).
module proj_unidade_controle #(
  parameter int ESPERA_GERADOR = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       temJogada,
  input  logic       acertou,
  input  logic       fimT,
  output logic       novaJogada,
  output logic       registraR,
  output logic       zeraR,
  output logic       zeraT,
  output logic       zeraP,
  output logic       contaT,
  output logic       decresceT,
  output logic       contaP,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    inicial        = 4'd0,
    preparacao     = 4'd1,
    nova_jogada    = 4'd2,
    aguarda_gerador= 4'd3,
    espera_jogada  = 4'd4,
    registra       = 4'd5,
    compara        = 4'd6,
    acerto         = 4'd7,
    erro           = 4'd8,
    fim_jogo       = 4'd15
  } estado_t;

  localparam logic [3:0] CARGA_ESPERA = 4'(ESPERA_GERADOR - 1);

  estado_t    estadoAtual;
  estado_t    proximoEstado;
  logic [3:0] contadorEspera;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estadoAtual    <= inicial;
      contadorEspera <= 4'd0;
    end else begin
      estadoAtual <= proximoEstado;
      // Counter is loaded on the way in so it reads ESPERA_GERADOR-1 on the first wait cycle
      if (estadoAtual == nova_jogada)
        contadorEspera <= CARGA_ESPERA;
      else if (estadoAtual == aguarda_gerador && contadorEspera != 4'd0)
        contadorEspera <= contadorEspera - 4'd1;
    end
  end

  always_comb begin
    proximoEstado = estadoAtual;
    case (estadoAtual)
      inicial:         if (iniciar) proximoEstado = preparacao;
      preparacao:      proximoEstado = nova_jogada;
      nova_jogada:     proximoEstado = aguarda_gerador;
      aguarda_gerador: begin
        // temJogada deliberately ignored while the generator settles
        if (fimT)                         proximoEstado = fim_jogo;
        else if (contadorEspera == 4'd0)  proximoEstado = espera_jogada;
      end
      espera_jogada: begin
        if (fimT)           proximoEstado = fim_jogo;
        else if (temJogada) proximoEstado = registra;
      end
      registra:        proximoEstado = compara;
      compara: begin
        if (fimT)         proximoEstado = fim_jogo;
        else if (acertou) proximoEstado = acerto;
        else              proximoEstado = erro;
      end
      acerto:          proximoEstado = nova_jogada;
      erro:            proximoEstado = espera_jogada;
      fim_jogo:        if (iniciar) proximoEstado = preparacao;
      default:         proximoEstado = inicial;
    endcase
  end

  always_comb begin
    novaJogada = 1'b0;
    registraR  = 1'b0;
    zeraR      = 1'b0;
    zeraT      = 1'b0;
    zeraP      = 1'b0;
    contaT     = 1'b0;
    contaP     = 1'b0;
    pronto     = 1'b0;
    case (estadoAtual)
      preparacao: begin
        zeraT = 1'b1;
        zeraR = 1'b1;
        zeraP = 1'b1;
      end
      nova_jogada: begin
        novaJogada = 1'b1;
        zeraR      = 1'b1;
      end
      aguarda_gerador: contaT = 1'b1;
      espera_jogada:   contaT = 1'b1;
      registra: begin
        registraR = 1'b1;
        contaT    = 1'b1;
      end
      compara:  contaT = 1'b1;
      acerto:   contaP = 1'b1;
      erro:     zeraR  = 1'b1;
      fim_jogo: pronto = 1'b1;
      default:  ;
    endcase
  end

`ifdef PENALIDADE_ERRO_EN
  assign decresceT = (estadoAtual == erro);
`else
  assign decresceT = 1'b0;
`endif

  assign db_estado = estadoAtual;

endmodule

// File: tb/tb_proj_unidade_controle.sv
// Self-checking bench for proj_unidade_controle: directed game scenarios checked
// every cycle against a behavioural model, plus literal expected sequences.
module tb_proj_unidade_controle;

  localparam int ESP = 2;
`ifdef PENALIDADE_ERRO_EN
  localparam logic PEN = 1'b1;
`else
  localparam logic PEN = 1'b0;
`endif

  // Expected outputs per state code, packed as
  // {novaJogada, registraR, zeraR, zeraT, zeraP, contaT, decresceT, contaP, pronto}
  localparam logic [8:0] OUT_TAB [16] = '{
    9'b000000000, 9'b001110000, 9'b101000000, 9'b000001000,
    9'b000001000, 9'b010001000, 9'b000001000, 9'b000000010,
    (9'b001000000 | {6'b0, PEN, 2'b0}),
    9'b000000000, 9'b000000000, 9'b000000000, 9'b000000000,
    9'b000000000, 9'b000000000, 9'b000000001
  };

  logic clock = 1'b0;
  logic reset, iniciar, temJogada, acertou, fimT;
  logic novaJogada, registraR, zeraR, zeraT, zeraP, contaT, decresceT, contaP, pronto;
  logic [3:0] db_estado;

  int tests = 0;
  int fails = 0;
  int mState = 0;
  int mRest  = 0;

  always #5 clock = ~clock;

  proj_unidade_controle #(.ESPERA_GERADOR(ESP)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .temJogada(temJogada),
    .acertou(acertou), .fimT(fimT), .novaJogada(novaJogada), .registraR(registraR),
    .zeraR(zeraR), .zeraT(zeraT), .zeraP(zeraP), .contaT(contaT),
    .decresceT(decresceT), .contaP(contaP), .pronto(pronto), .db_estado(db_estado)
  );

  function automatic logic [8:0] dutOuts();
    return {novaJogada, registraR, zeraR, zeraT, zeraP, contaT, decresceT, contaP, pronto};
  endfunction

  // Game rules: mRest counts the generator-wait cycles still owed.
  task automatic modelStep();
    if (!reset) begin
      mState = 0;
    end else begin
      case (mState)
        0:  if (iniciar) mState = 1;
        1:  mState = 2;
        2:  begin mState = 3; mRest = ESP; end
        3:  begin
              mRest = mRest - 1;
              if (fimT) mState = 15;
              else if (mRest == 0) mState = 4;
            end
        4:  if (fimT) mState = 15; else if (temJogada) mState = 5;
        5:  mState = 6;
        6:  mState = fimT ? 15 : (acertou ? 7 : 8);
        7:  mState = 2;
        8:  mState = 4;
        15: if (iniciar) mState = 1;
        default: mState = 0;
      endcase
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One clock: advance the model with the current inputs, then check the DUT.
  task automatic cyc();
    @(posedge clock);
    modelStep();
    #1;
    chk("db_estado vs model", int'(db_estado), mState);
    chk("outputs vs model", int'(dutOuts()), int'(OUT_TAB[mState[3:0]]));
  endtask

  task automatic startTo4();
    iniciar = 1'b1; cyc();
    chk("start zera pulses", int'({zeraT, zeraR, zeraP}), 7);
    iniciar = 1'b0;
    repeat (4) cyc();
    chk("start reaches espera", int'(db_estado), 4);
  endtask

  int seq[$];
  int cntP, cntNova, cntReg;

  initial begin
    reset = 1'b0; iniciar = 1'b0; temJogada = 1'b0; acertou = 1'b0; fimT = 1'b0;
    #2;
    repeat (2) cyc();
    chk("reset state", int'(db_estado), 0);
    chk("reset outputs", int'(dutOuts()), 0);
    reset = 1'b1;
    cyc();
    chk("idle without iniciar", int'(db_estado), 0);

    // Hit path
    startTo4();
    cyc();
    temJogada = 1'b1; acertou = 1'b1; cyc();
    temJogada = 1'b0;
    seq = {int'(db_estado)};
    cntP = int'(contaP);
    repeat (6) begin cyc(); seq.push_back(int'(db_estado)); cntP += int'(contaP); end
    chk("hit seq len", seq.size(), 7);
    begin
      int expSeq[7] = '{5, 6, 7, 2, 3, 3, 4};
      for (int i = 0; i < 7; i++) chk("hit seq", seq[i], expSeq[i]);
    end
    chk("hit contaP count", cntP, 1);
    acertou = 1'b0;

    // Miss path
    temJogada = 1'b1; cyc(); temJogada = 1'b0;
    chk("miss registra", int'(db_estado), 5);
    cntNova = 0;
    cyc(); chk("miss compara", int'(db_estado), 6); cntNova += int'(novaJogada);
    cyc(); chk("miss erro", int'(db_estado), 8); cntNova += int'(novaJogada);
    chk("miss zeraR", int'(zeraR), 1);
    chk("miss decresceT", int'(decresceT), int'(PEN));
    cyc(); chk("miss back to espera", int'(db_estado), 4); cntNova += int'(novaJogada);
    chk("miss no novaJogada", cntNova, 0);

    // Generator wait ignores temJogada
    temJogada = 1'b1; acertou = 1'b1; cyc(); temJogada = 1'b0;
    repeat (3) cyc();
    chk("gen nova_jogada", int'(db_estado), 2);
    acertou = 1'b0;
    temJogada = 1'b1;
    cyc(); chk("gen wait 1", int'(db_estado), 3);
    cyc(); chk("gen wait 2", int'(db_estado), 3);
    cyc(); chk("gen done", int'(db_estado), 4);
    temJogada = 1'b0;
    cyc(); chk("gen pulse lost", int'(db_estado), 4);

    // Timeout beats simultaneous move
    fimT = 1'b1; temJogada = 1'b1; cyc();
    fimT = 1'b0; temJogada = 1'b0;
    chk("timeout fim_jogo", int'(db_estado), 15);
    cntReg = int'(registraR);
    repeat (3) begin cyc(); cntReg += int'(registraR); chk("pronto held", int'(pronto), 1); end
    chk("timeout no registraR", cntReg, 0);
    iniciar = 1'b1; cyc();
    chk("restart preparacao", int'(db_estado), 1);
    chk("restart pronto low", int'(pronto), 0);
    iniciar = 1'b0;
    repeat (2) cyc();
    chk("restart aguarda", int'(db_estado), 3);

    // Timeout during generator wait
    fimT = 1'b1; cyc(); fimT = 1'b0;
    chk("timeout in aguarda", int'(db_estado), 15);

    // Held iniciar through fim_jogo, then timeout in compara
    iniciar = 1'b1; cyc(); cyc();
    chk("held iniciar leaves", int'(db_estado), 2);
    iniciar = 1'b0;
    repeat (3) cyc();
    temJogada = 1'b1; acertou = 1'b1; cyc(); temJogada = 1'b0;
    cyc(); chk("reach compara", int'(db_estado), 6);
    fimT = 1'b1; cyc(); fimT = 1'b0;
    chk("fimT beats acertou", int'(db_estado), 15);
    chk("no contaP on timeout", int'(contaP), 0);
    acertou = 1'b0;

    // Mid-move reset from compara
    startTo4();
    temJogada = 1'b1; cyc(); temJogada = 1'b0;
    cyc(); chk("midreset compara", int'(db_estado), 6);
    reset = 1'b0; cyc();
    chk("midreset state", int'(db_estado), 0);
    chk("midreset outputs", int'(dutOuts()), 0);
    reset = 1'b1; cyc();
    chk("midreset stays", int'(db_estado), 0);
    chk("midreset no pulses", int'({contaP, zeraR}), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
